conv_stream_lanes: RTL
======================

# conv_stream_lanes

Parametrised 1-D valid-mode convolution engine with stream handshakes on X, F and Y. It buffers one X vector and one F vector, then computes every output position using LANES time-multiplexed multipliers rather than one multiplier per filter tap. It supports a configurable stride, a stallable registered output and an optional saturating output narrowing. It sits between the X/F stream sources and the Y consumer.

## Interface
- X_SIZE, 128, samples per X vector
- F_SIZE, 32, taps per filter
- LANES, 8, parallel multipliers; must divide F_SIZE
- STRIDE, 1, output step in X samples; (X_SIZE-F_SIZE)%STRIDE must be 0
- DW_X, 8, signed X sample width
- DW_F, 8, signed F tap width
- OUT_W, 16, signed Y width; must be ≤ ACC_W
- Derived localparams:
  - ACC_W = DW_X+DW_F+$clog2(F_SIZE)
  - BEATS = F_SIZE/LANES
  - N_OUT = (X_SIZE-F_SIZE)/STRIDE+1
- Clock and reset: clk, the clock; reset, synchronous, active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s_valid_x  in  1  X sample valid
- s_ready_x  out  1  X memory accepting
- s_data_x  in  DW_X  signed X sample
- s_valid_f  in  1  F tap valid
- s_ready_f  out  1  F memory accepting
- s_data_f  in  DW_F  signed F tap
- m_valid_y  out  1  Y result valid
- m_ready_y  in  1  consumer accepting
- m_data_y  out  OUT_W  signed convolution result

## Operation
- **States:** LOAD, COMPUTE, OUT.
- **Reset:**
  - State goes to LOAD; all counters and the accumulator clear.
  - m_valid_y=0, m_data_y=0; s_ready_x=1 and s_ready_f=1 from the first cycle after reset.
  - A reset mid-frame discards all partial data.
- **LOAD:**
  - A beat is accepted when valid&&ready. X and F are loaded independently, in order, at address 0 upward; both may be accepted in the same cycle.
  - s_ready_x = (xcnt<X_SIZE) in LOAD; s_ready_f = (fcnt<F_SIZE) in LOAD. Both are 0 in the other states.
  - Data presented while ready is low is ignored.
  - When xcnt==X_SIZE and fcnt==F_SIZE, go to COMPUTE the next cycle with base=0, beat=0, acc=0.
- **COMPUTE:**
  - Each cycle: acc += Σ over l=0..LANES-1 of x[base+beat*LANES+l]*f[beat*LANES+l].
  - Products are full DW_X+DW_F; sums are sign-extended to ACC_W, so no overflow can occur internally.
  - On beat==BEATS-1: register the narrowed acc+partial into m_data_y, set m_valid_y, go to OUT.
- **OUT:**
  - m_data_y and m_valid_y are held stable until m_ready_y.
  - On the handshake: if this is the last output (N_OUT-th), go to LOAD, clear counters and drop m_valid_y. Otherwise base += STRIDE, acc=0, beat=0, drop m_valid_y and go to COMPUTE.
- Neither memory accepts new data until all N_OUT outputs have been consumed.

## Timing
- Readies are combinational from registered state and counters; there is no combinational path from any valid to any ready.
- m_valid_y rises exactly BEATS cycles after entering COMPUTE.
- The COMPUTE entry cycle is one cycle after the final X/F load beat.
- Per-output period is BEATS+1 cycles with m_ready_y held high. Each cycle m_ready_y is low adds one cycle.
- After the last Y handshake, s_ready_x and s_ready_f are 1 on the next cycle.

## Configuration
- **CONV_SAT_EN defined:** m_data_y is acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- **CONV_SAT_EN undefined:** m_data_y = acc[OUT_W-1:0] (two's-complement wrap).

## Structure
- **Package conv_pkg:**
  - conv_state_t enum (LOAD, COMPUTE, OUT)
  - acc_width function (DW_X, DW_F, F_SIZE)
  - sat_narrow function, used under CONV_SAT_EN
- **Sub-module conv_lane_mac:**
  - Combinational LANES-wide multiply and adder tree.
  - Inputs: LANES X samples and LANES F taps. Output: ACC_W signed partial sum.
- The top level holds the X/F register arrays, the counters, the FSM and the output register.

## Test plan
- **Basic:** X_SIZE=8, F_SIZE=4, LANES=2, STRIDE=1; x=1..8, f=1,1,1,1, m_ready_y=1 → Y=10,14,18,22,26. Each Y is 3 cycles apart; readies return to 1 after the 5th Y.
- **Stride:** same data, STRIDE=2 → Y=10,18,26, then back to LOAD.
- **Saturation:** F_SIZE=4, OUT_W=16; x all 127, f all 127 → 32767 with CONV_SAT_EN, -1020 without. x all -128, f all 127 → -32768 with CONV_SAT_EN, 512 without.
- **Backpressure:** m_ready_y=0 for 10 cycles on the 2nd Y → m_data_y stable at 14, no 3rd result early, and the sequence completes unchanged.
- **Interleaved load:** F fully loaded before X, with s_valid_x toggling every other cycle → COMPUTE starts the cycle after the 8th X beat; extra F beats are not accepted (s_ready_f=0).
- **Reset mid-COMPUTE:** assert reset during the 3rd output → m_valid_y=0, both readies 1 the next cycle. A fresh frame then produces correct results.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_stream_lanes engine.
// CONV_SAT_EN selects the saturating narrowing helper at the top level.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } conv_state_t;

  // Accumulator width that holds a full F_SIZE-tap dot product without overflow.
  function automatic int acc_width(input int dw_x, input int dw_f, input int f_size);
    return dw_x + dw_f + $clog2(f_size);
  endfunction

  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                    input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// Combinational LANES-wide signed multiply and reduction into an ACC_W partial sum.
module conv_lane_mac #(
  parameter int LANES = 8,
  parameter int DW_X  = 8,
  parameter int DW_F  = 8,
  parameter int ACC_W = 21
) (
  input  logic signed [DW_X-1:0]  x_i [LANES],
  input  logic signed [DW_F-1:0]  f_i [LANES],
  output logic signed [ACC_W-1:0] sum_o
);

  localparam int PW = DW_X + DW_F;

  logic signed [PW-1:0] prod [LANES];

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = PW'(x_i[l]) * PW'(f_i[l]);
      sum_o   = sum_o + ACC_W'(prod[l]);
    end
  end

endmodule

// File: rtl/conv_stream_lanes.sv
// Valid-mode 1-D convolution: buffer X and F, then time-multiplex LANES MACs per output.
// Define CONV_SAT_EN to clamp Y to OUT_W instead of two's-complement wrapping.
module conv_stream_lanes
  import conv_pkg::*;
#(
  parameter int X_SIZE = 128,
  parameter int F_SIZE = 32,
  parameter int LANES  = 8,
  parameter int STRIDE = 1,
  parameter int DW_X   = 8,
  parameter int DW_F   = 8,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  input  logic signed [DW_X-1:0]  s_data_x,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic signed [DW_F-1:0]  s_data_f,
  output logic                    m_valid_y,
  input  logic                    m_ready_y,
  output logic signed [OUT_W-1:0] m_data_y,
  output conv_state_t             dbg_state
);

  localparam int ACC_W = acc_width(DW_X, DW_F, F_SIZE);
  localparam int BEATS = F_SIZE / LANES;
  localparam int N_OUT = (X_SIZE - F_SIZE) / STRIDE + 1;
  localparam int XW    = $clog2(X_SIZE + 1);
  localparam int FW    = $clog2(F_SIZE + 1);
  localparam int XAW   = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int FAW   = (F_SIZE > 1) ? $clog2(F_SIZE) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  // Handshake rule on every port: a beat transfers on a rising clk edge where
  // valid && ready; readies depend only on registered state, never on valids.

  logic signed [DW_X-1:0]  x_mem_q [X_SIZE];
  logic signed [DW_F-1:0]  f_mem_q [F_SIZE];
  conv_state_t             state_q, state_d;
  logic [XW-1:0]           xcnt_q, xcnt_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic [XAW-1:0]          base_q, base_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [OW-1:0]           ocnt_q, ocnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, partial, acc_sum;
  logic                    y_valid_q, y_valid_d;
  logic signed [OUT_W-1:0] y_data_q, y_data_d, y_narrow;
  logic signed [DW_X-1:0]  lane_x [LANES];
  logic signed [DW_F-1:0]  lane_f [LANES];
  logic                    x_fire, f_fire;

  assign s_ready_x = (state_q == LOAD) && (xcnt_q < XW'(X_SIZE));
  assign s_ready_f = (state_q == LOAD) && (fcnt_q < FW'(F_SIZE));
  assign x_fire    = s_valid_x && s_ready_x;
  assign f_fire    = s_valid_f && s_ready_f;
  assign m_valid_y = y_valid_q;
  assign m_data_y  = y_data_q;
  assign dbg_state = state_q;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_x[l] = x_mem_q[XAW'(int'(base_q) + int'(beat_q) * LANES + l)];
      lane_f[l] = f_mem_q[FAW'(int'(beat_q) * LANES + l)];
    end
  end

  conv_lane_mac #(
    .LANES(LANES),
    .DW_X (DW_X),
    .DW_F (DW_F),
    .ACC_W(ACC_W)
  ) u_mac (
    .x_i  (lane_x),
    .f_i  (lane_f),
    .sum_o(partial)
  );

  assign acc_sum = acc_q + partial;

`ifdef CONV_SAT_EN
  assign y_narrow = OUT_W'(sat_narrow(64'(acc_sum), OUT_W));
`else
  assign y_narrow = acc_sum[OUT_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    xcnt_d    = xcnt_q;
    fcnt_d    = fcnt_q;
    base_d    = base_q;
    beat_d    = beat_q;
    ocnt_d    = ocnt_q;
    acc_d     = acc_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    case (state_q)
      LOAD: begin
        if (x_fire) xcnt_d = xcnt_q + XW'(1);
        if (f_fire) fcnt_d = fcnt_q + FW'(1);
        // Leave on the edge that completes both memories so COMPUTE follows the last beat.
        if (xcnt_d == XW'(X_SIZE) && fcnt_d == FW'(F_SIZE)) begin
          state_d = COMPUTE;
          base_d  = '0;
          beat_d  = '0;
          acc_d   = '0;
        end
      end
      COMPUTE: begin
        acc_d  = acc_sum;
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(BEATS - 1)) begin
          y_data_d  = y_narrow;
          y_valid_d = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (m_ready_y) begin
          y_valid_d = 1'b0;
          acc_d     = '0;
          beat_d    = '0;
          if (ocnt_q == OW'(N_OUT - 1)) begin
            state_d = LOAD;
            xcnt_d  = '0;
            fcnt_d  = '0;
            ocnt_d  = '0;
            base_d  = '0;
          end else begin
            state_d = COMPUTE;
            ocnt_d  = ocnt_q + OW'(1);
            base_d  = base_q + XAW'(STRIDE);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_fire) x_mem_q[xcnt_q[XAW-1:0]] <= s_data_x;
    if (f_fire) f_mem_q[fcnt_q[FAW-1:0]] <= s_data_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      xcnt_q    <= '0;
      fcnt_q    <= '0;
      base_q    <= '0;
      beat_q    <= '0;
      ocnt_q    <= '0;
      acc_q     <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      xcnt_q    <= xcnt_d;
      fcnt_q    <= fcnt_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      ocnt_q    <= ocnt_d;
      acc_q     <= acc_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
    end
  end

endmodule
